paged_burst_ctrl: RTL and testbench

PAGED_BURST_CTRL -- requirements
Module: paged_burst_ctrl

---
 rtl/paged_burst_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_paged_burst_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/paged_burst_ctrl.sv
// Paged burst memory controller behind an Avalon-MM slave port.
// Writes merge per byte lane; reads stream one registered beat per cycle.
module paged_burst_ctrl #(
  parameter int AW = 16,
  parameter int DW = 64,
  parameter int MAX_BURST = 8,
  parameter int PAGE_COUNT = 4,
  parameter int PAGE_SIZE = 64,
  parameter logic [DW-1:0] FILL = DW'(16'hDEAD)
) (
  input  logic                                               clock,
  input  logic                                               reset,
  input  logic [AW-1:0]                                      bus_address,
  input  logic                                               bus_read,
  input  logic                                               bus_write,
  input  logic [DW-1:0]                                      bus_writedata,
  input  logic [DW/8-1:0]                                    bus_byteenable,
  input  logic [$clog2(MAX_BURST):0]                         bus_burstcount,
  output logic [DW-1:0]                                      bus_readdata,
  output logic                                               bus_readdatavalid,
  output logic                                               bus_waitrequest,
  input  logic [((PAGE_COUNT > 1) ? $clog2(PAGE_COUNT) : 1)-1:0] page_number,
  input  logic [PAGE_COUNT-1:0]                              page_lock,
  output logic [15:0]                                        drop_count,
  output logic                                               busy
);

  localparam int BYTES = DW / 8;
  localparam int OFF_W = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int WA_W  = AW - OFF_W;
  localparam int AC_W  = WA_W + 1;
  localparam int CW    = $clog2(MAX_BURST) + 1;
  localparam int PGW   = (PAGE_COUNT > 1) ? $clog2(PAGE_COUNT) : 1;
  localparam int DEPTH = PAGE_COUNT * PAGE_SIZE;
  localparam int MW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t           state_q, state_d;
  logic [AC_W-1:0]  addr_q, addr_d;
  logic [PGW-1:0]   page_q, page_d;
  logic [CW-1:0]    remain_q, remain_d;
  logic [DW-1:0]    readdata_q, readdata_d;
  logic             rvalid_q, rvalid_d;
  logic [15:0]      drop_q, drop_d;
  logic [DW-1:0]    mem_q [DEPTH];

  logic [AC_W-1:0]  acc_addr;
  logic [CW-1:0]    acc_len;
  logic             wr_beat, rd_beat, wr_hit;
  logic [PGW-1:0]   wr_page, rd_page;
  logic [AC_W-1:0]  wr_addr, rd_addr;
  logic [DW-1:0]    rd_word, mem_old, mem_wdata;
  logic [MW-1:0]    mem_idx;
  logic             mem_we;

  // The extra top bit keeps the word address from wrapping back into the page.
  assign acc_addr = {1'b0, bus_address[AW-1:OFF_W]};

  function automatic logic in_page(input logic [PGW-1:0] pg, input logic [AC_W-1:0] a);
    return (int'(pg) < PAGE_COUNT) && (int'(a) < PAGE_SIZE);
  endfunction

  function automatic logic [MW-1:0] word_idx(input logic [PGW-1:0] pg, input logic [AC_W-1:0] a);
    return MW'(int'(pg) * PAGE_SIZE + int'(a));
  endfunction

  always_comb begin
    acc_len = bus_burstcount;
    if (bus_burstcount == '0) begin
      acc_len = CW'(1);
    end else if (int'(bus_burstcount) > MAX_BURST) begin
      acc_len = CW'(MAX_BURST);
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    page_d   = page_q;
    remain_d = remain_q;
    wr_beat  = 1'b0;
    wr_page  = page_q;
    wr_addr  = addr_q;
    rd_beat  = 1'b0;
    rd_page  = page_q;
    rd_addr  = addr_q;
    unique case (state_q)
      IDLE: begin
        if (bus_write) begin
          wr_beat  = 1'b1;
          wr_page  = page_number;
          wr_addr  = acc_addr;
          page_d   = page_number;
          addr_d   = acc_addr + 1'b1;
          remain_d = acc_len - 1'b1;
          state_d  = (acc_len == CW'(1)) ? IDLE : WRITE;
        end else if (bus_read) begin
          rd_beat  = 1'b1;
          rd_page  = page_number;
          rd_addr  = acc_addr;
          page_d   = page_number;
          addr_d   = acc_addr + 1'b1;
          remain_d = acc_len - 1'b1;
          state_d  = READ;
        end
      end
      WRITE: begin
        if (bus_write) begin
          wr_beat  = 1'b1;
          addr_d   = addr_q + 1'b1;
          remain_d = remain_q - 1'b1;
          if (remain_q == CW'(1)) begin
            state_d = IDLE;
          end
        end
      end
      READ: begin
        // Beat 0 was registered at acceptance, so READ only streams the rest.
        if (remain_q == '0) begin
          state_d = IDLE;
        end else begin
          rd_beat  = 1'b1;
          addr_d   = addr_q + 1'b1;
          remain_d = remain_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_word    = in_page(rd_page, rd_addr) ? mem_q[word_idx(rd_page, rd_addr)] : FILL;
    readdata_d = rd_beat ? rd_word : readdata_q;
    rvalid_d   = rd_beat;
    wr_hit     = in_page(wr_page, wr_addr) && !page_lock[wr_page];
    mem_we     = wr_beat && wr_hit;
    mem_idx    = word_idx(wr_page, wr_addr);
    mem_old    = mem_q[mem_idx];
    mem_wdata  = mem_old;
    for (int b = 0; b < BYTES; b++) begin
      if (bus_byteenable[b]) begin
        mem_wdata[8*b +: 8] = bus_writedata[8*b +: 8];
      end
    end
    drop_d = drop_q;
    if (wr_beat && !wr_hit && drop_q != 16'hFFFF) begin
      drop_d = drop_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      page_q     <= '0;
      remain_q   <= '0;
      readdata_q <= '0;
      rvalid_q   <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      page_q     <= page_d;
      remain_q   <= remain_d;
      readdata_q <= readdata_d;
      rvalid_q   <= rvalid_d;
      drop_q     <= drop_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[mem_idx] <= mem_wdata;
    end
  end

  assign bus_readdata      = readdata_q;
  assign bus_readdatavalid = rvalid_q;
  assign bus_waitrequest   = (state_q == READ);
  assign busy              = (state_q != IDLE);
  assign drop_count        = drop_q;

endmodule

// File: tb/tb_paged_burst_ctrl.sv
// Self-checking bench for paged_burst_ctrl: vector table plus hand-written
// corner sequences, with read beats checked against a scoreboard queue.
module tb_paged_burst_ctrl;

  localparam int PS = 64;
  localparam int PC = 4;
  localparam logic [63:0] FILL = 64'hDEAD;

  logic        clock;
  logic        reset;
  logic [15:0] bus_address;
  logic        bus_read;
  logic        bus_write;
  logic [63:0] bus_writedata;
  logic [7:0]  bus_byteenable;
  logic [3:0]  bus_burstcount;
  logic [63:0] bus_readdata;
  logic        bus_readdatavalid;
  logic        bus_waitrequest;
  logic [1:0]  page_number;
  logic [3:0]  page_lock;
  logic [15:0] drop_count;
  logic        busy;

  paged_burst_ctrl dut (
    .clock             (clock),
    .reset             (reset),
    .bus_address       (bus_address),
    .bus_read          (bus_read),
    .bus_write         (bus_write),
    .bus_writedata     (bus_writedata),
    .bus_byteenable    (bus_byteenable),
    .bus_burstcount    (bus_burstcount),
    .bus_readdata      (bus_readdata),
    .bus_readdatavalid (bus_readdatavalid),
    .bus_waitrequest   (bus_waitrequest),
    .page_number       (page_number),
    .page_lock         (page_lock),
    .drop_count        (drop_count),
    .busy              (busy)
  );

  typedef struct {
    bit          is_write;
    int          page;
    int          addr;
    int          burst;
    logic [63:0] base;
    logic [7:0]  be;
    logic [3:0]  lock;
    int          exp_drop;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    int          cyc;
  } exp_t;

  vec_t        vecs [16];
  exp_t        sbq [$];
  exp_t        mon_e;
  logic [63:0] mdl [PC*PS];
  int          mdl_drop;
  int          checks;
  int          failures;
  int          cyc;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int clamp_len(input int burst);
    if (burst == 0) return 1;
    if (burst > 8) return 8;
    return burst;
  endfunction

  function automatic logic [63:0] mdl_read(input int pg, input int w);
    if (w >= PS) return FILL;
    return mdl[pg*PS + w];
  endfunction

  task automatic mdl_write(input int pg, input int w, input logic [63:0] data, input logic [7:0] be);
    if (w >= PS || page_lock[pg]) begin
      if (mdl_drop < 65535) mdl_drop++;
    end else begin
      for (int b = 0; b < 8; b++) begin
        if (be[b]) mdl[pg*PS + w][8*b +: 8] = data[8*b +: 8];
      end
    end
  endtask

  task automatic mdl_clear();
    for (int i = 0; i < PC*PS; i++) mdl[i] = '0;
    mdl_drop = 0;
  endtask

  // Every read beat must match the oldest scoreboard entry, including its cycle.
  always @(negedge clock) begin
    if (reset && bus_readdatavalid) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_beat actual=%h expected=none time=%0t", bus_readdata, $time);
      end else begin
        mon_e = sbq.pop_front();
        checkOutput("rd_data", bus_readdata, mon_e.data);
        checkOutput("rd_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  task automatic wait_idle();
    for (int t = 0; t < 40 && busy; t++) begin
      @(posedge clock); #1;
    end
    checkOutput("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic do_read(input int pg, input int addr, input int burst, input int mid_page);
    int n;
    n = clamp_len(burst);
    @(posedge clock); #1;
    page_number    = 2'(pg);
    bus_address    = 16'(addr);
    bus_burstcount = 4'(burst);
    bus_read       = 1'b1;
    for (int k = 0; k < n; k++) sbq.push_back('{mdl_read(pg, addr/8 + k), cyc + 1 + k});
    @(posedge clock); #1;
    bus_read = 1'b0;
    checkOutput("rd_waitreq", 64'(bus_waitrequest), 64'd1);
    checkOutput("rd_busy", 64'(busy), 64'd1);
    if (mid_page >= 0) page_number = 2'(mid_page);
    wait_idle();
    checkOutput("rd_sb_empty", 64'(sbq.size()), 64'd0);
    checkOutput("rd_valid_idle", 64'(bus_readdatavalid), 64'd0);
  endtask

  task automatic do_write(input int pg, input int addr, input int burst, input logic [63:0] base,
                          input logic [7:0] be, input int stall_at, input int lock_at,
                          input logic [3:0] lock_val);
    int n;
    n = clamp_len(burst);
    @(posedge clock); #1;
    page_number    = 2'(pg);
    bus_address    = 16'(addr);
    bus_burstcount = 4'(burst);
    bus_writedata  = base;
    bus_byteenable = be;
    bus_write      = 1'b1;
    mdl_write(pg, addr/8, base, be);
    for (int k = 1; k < n; k++) begin
      @(posedge clock); #1;
      if (k == 1) begin
        checkOutput("wr_waitreq", 64'(bus_waitrequest), 64'd0);
        checkOutput("wr_busy", 64'(busy), 64'd1);
        page_number = 2'(pg + 1);
      end
      if (k == stall_at) begin
        bus_write = 1'b0;
        @(posedge clock); #1;
        checkOutput("wr_stall_busy", 64'(busy), 64'd1);
        bus_write = 1'b1;
      end
      if (k == lock_at) page_lock = lock_val;
      bus_writedata = base + 64'(k);
      mdl_write(pg, addr/8 + k, base + 64'(k), be);
    end
    @(posedge clock); #1;
    bus_write = 1'b0;
    checkOutput("wr_done_idle", 64'(busy), 64'd0);
    checkOutput("wr_drop", 64'(drop_count), 64'(mdl_drop));
  endtask

  task automatic applyStimulus(input vec_t v);
    page_lock = v.lock;
    if (v.is_write) do_write(v.page, v.addr, v.burst, v.base, v.be, -1, -1, 4'b0);
    else            do_read(v.page, v.addr, v.burst, -1);
    checkOutput("tbl_drop", 64'(drop_count), 64'(v.exp_drop));
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    reset          = 1'b0;
    bus_address    = '0;
    bus_read       = 1'b0;
    bus_write      = 1'b0;
    bus_writedata  = '0;
    bus_byteenable = '0;
    bus_burstcount = '0;
    page_number    = '0;
    page_lock      = '0;
    mdl_clear();

    #1;
    checkOutput("rst_valid", 64'(bus_readdatavalid), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_drop", 64'(drop_count), 64'd0);
    checkOutput("rst_rdata", bus_readdata, 64'd0);
    checkOutput("rst_waitreq", 64'(bus_waitrequest), 64'd0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;

    vecs[0]  = '{1, 2, 'h000, 4,  64'd1,                 8'hFF, 4'b0000, 0};
    vecs[1]  = '{0, 2, 'h000, 4,  64'd0,                 8'h00, 4'b0000, 0};
    vecs[2]  = '{1, 0, 'h008, 1,  64'h1122334455667788,  8'hFF, 4'b0000, 0};
    vecs[3]  = '{1, 0, 'h008, 1,  64'd0,                 8'h0F, 4'b0000, 0};
    vecs[4]  = '{0, 0, 'h008, 1,  64'd0,                 8'h00, 4'b0000, 0};
    vecs[5]  = '{1, 0, 'h040, 3,  64'hA0,                8'hFF, 4'b0000, 0};
    vecs[6]  = '{1, 1, 'h040, 3,  64'hB0,                8'hFF, 4'b0010, 3};
    vecs[7]  = '{0, 1, 'h040, 3,  64'd0,                 8'h00, 4'b0010, 3};
    vecs[8]  = '{0, 0, 'h040, 3,  64'd0,                 8'h00, 4'b0000, 3};
    vecs[9]  = '{0, 0, 'h1F0, 4,  64'd0,                 8'h00, 4'b0000, 3};
    vecs[10] = '{1, 0, 'h1F0, 4,  64'hC0,                8'hFF, 4'b0000, 5};
    vecs[11] = '{0, 0, 'h1F0, 4,  64'd0,                 8'h00, 4'b0000, 5};
    vecs[12] = '{1, 3, 'h000, 0,  64'hE0,                8'hFF, 4'b0000, 5};
    vecs[13] = '{0, 3, 'h000, 12, 64'd0,                 8'h00, 4'b0000, 5};
    vecs[14] = '{1, 3, 'h008, 15, 64'hF0,                8'hFF, 4'b0000, 5};
    vecs[15] = '{0, 3, 'h000, 8,  64'd0,                 8'h00, 4'b0000, 5};

    for (int i = 0; i < 16; i++) applyStimulus(vecs[i]);
    page_lock = '0;

    // Page select changes mid-read must not redirect the remaining beats.
    do_read(0, 'h040, 3, 3);

    // Read and write together in IDLE: the write is taken, the read dropped.
    @(posedge clock); #1;
    page_number    = 2'd0;
    bus_address    = 16'h0100;
    bus_burstcount = 4'd1;
    bus_writedata  = 64'h77;
    bus_byteenable = 8'hFF;
    bus_read       = 1'b1;
    bus_write      = 1'b1;
    mdl_write(0, 'h100/8, 64'h77, 8'hFF);
    @(posedge clock); #1;
    bus_read  = 1'b0;
    bus_write = 1'b0;
    checkOutput("rw_no_read", 64'(bus_readdatavalid), 64'd0);
    checkOutput("rw_idle", 64'(busy), 64'd0);
    do_read(0, 'h100, 1, -1);

    do_write(2, 'h080, 4, 64'h300, 8'hFF, 2, -1, 4'b0);
    do_read(2, 'h080, 4, -1);

    page_lock = '0;
    do_write(1, 'h000, 3, 64'h400, 8'hFF, -1, 2, 4'b0010);
    page_lock = '0;
    do_read(1, 'h000, 3, -1);

    // Asynchronous reset in the middle of a burst-8 read.
    @(posedge clock); #1;
    page_number    = 2'd2;
    bus_address    = 16'h0000;
    bus_burstcount = 4'd8;
    bus_read       = 1'b1;
    for (int k = 0; k < 8; k++) sbq.push_back('{mdl_read(2, k), cyc + 1 + k});
    @(posedge clock); #1;
    bus_read = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    #2;
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 64'(bus_readdatavalid), 64'd0);
    checkOutput("mid_rst_busy", 64'(busy), 64'd0);
    checkOutput("mid_rst_rdata", bus_readdata, 64'd0);
    checkOutput("mid_rst_waitreq", 64'(bus_waitrequest), 64'd0);
    checkOutput("mid_rst_drop", 64'(drop_count), 64'd0);
    sbq.delete();
    mdl_clear();
    @(posedge clock); #1;
    reset          = 1'b1;
    page_number    = 2'd2;
    bus_address    = 16'h0000;
    bus_burstcount = 4'd4;
    bus_read       = 1'b1;
    for (int k = 0; k < 4; k++) sbq.push_back('{mdl_read(2, k), cyc + 1 + k});
    @(posedge clock); #1;
    bus_read = 1'b0;
    wait_idle();
    checkOutput("post_rst_sb_empty", 64'(sbq.size()), 64'd0);
    do_read(0, 'h040, 3, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
